// File: rtl/noc_output_unit.sv
// Output-port unit for the NoC router: round-robin wormhole allocator, crossbar column
// and registered output stage driving a valid/ready link to the next hop.
module noc_output_unit #(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  output logic [NUM_IN-1:0]            pop_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         busy_out,
  output logic [NUM_IN-1:0]            owner_out,
  output logic                         err_out
);
  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [2:0] ID_HEAD = 3'b001;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [PTR_W-1:0]      own_idx_q, own_idx_d;
  logic [NUM_IN-1:0]     owner_q, owner_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  load_ok;
  logic                  found;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] sel_flit;
  logic [DATA_WIDTH-1:0] own_flit;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [NUM_IN-1:0]     bad_head;
  logic [NUM_IN-1:0]     pop;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_IN) begin
      s = s - NUM_IN;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  function automatic logic [2:0] flit_id(input logic [DATA_WIDTH-1:0] f);
    return f[DATA_WIDTH-1 -: 3];
  endfunction

  assign load_ok  = !valid_q || ready_in;
  assign sel_flit = data_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign own_flit = data_in[int'(own_idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_len  = sel_flit[DATA_WIDTH-4 -: LEN_WIDTH];

  // Round-robin search for the first requesting header at or after rr_q.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    cand     = '0;
    bad_head = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = wrap_add(rr_q, k);
      if (!found && req_in[cand] &&
          flit_id(data_in[int'(cand)*DATA_WIDTH +: DATA_WIDTH]) == ID_HEAD) begin
        found   = 1'b1;
        sel_idx = cand;
      end else begin
        found   = found;
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      bad_head[i] = req_in[i] && (flit_id(data_in[i*DATA_WIDTH +: DATA_WIDTH]) != ID_HEAD);
    end
  end

  // Next-state, pop and output-register load decisions.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    own_idx_d = own_idx_q;
    owner_d   = owner_q;
    rem_d     = rem_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_d     = err_q;
    pop       = '0;
    case (state_q)
      IDLE: begin
        err_d = err_q | (|bad_head);
        if (found && load_ok) begin
          pop[sel_idx] = 1'b1;
          data_d       = sel_flit;
          valid_d      = 1'b1;
          // Lengths 0 and 1 are both single-flit packets that never enter XFER.
          if (sel_len <= LEN_WIDTH'(1)) begin
            rem_d = '0;
            rr_d  = wrap_add(sel_idx, 1);
          end else begin
            rem_d     = sel_len - LEN_WIDTH'(1);
            own_idx_d = sel_idx;
            owner_d   = NUM_IN'(1) << sel_idx;
            state_d   = XFER;
          end
        end else if (ready_in) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      XFER: begin
        if (req_in[own_idx_q] && load_ok) begin
          pop[own_idx_q] = 1'b1;
          data_d         = own_flit;
          valid_d        = 1'b1;
          rem_d          = rem_q - LEN_WIDTH'(1);
          if (flit_id(own_flit) == ID_HEAD ||
              (flit_id(own_flit) == ID_TAIL && rem_q != LEN_WIDTH'(1))) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (flit_id(own_flit) == ID_TAIL || rem_q == LEN_WIDTH'(1)) begin
            state_d   = IDLE;
            rr_d      = wrap_add(own_idx_q, 1);
            own_idx_d = '0;
            owner_d   = '0;
          end else begin
            state_d   = XFER;
          end
        end else if (ready_in) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      own_idx_q <= '0;
      owner_q   <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      own_idx_q <= own_idx_d;
      owner_q   <= owner_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign pop_out   = rst ? '0 : pop;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy_out  = (state_q == XFER);
  assign owner_out = owner_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_noc_output_unit.sv
// Bench for noc_output_unit: directed scenarios plus random traffic, each cycle compared
// against a queue-based packet model of the output port.
module tb_noc_output_unit;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int LW = 12;
  localparam logic [2:0] HD = 3'b001;
  localparam logic [2:0] BD = 3'b010;
  localparam logic [2:0] TL = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]  pop_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b1;
  logic          busy_out;
  logic [N-1:0]  owner_out;
  logic          err_out;

  always #5 clk = ~clk;

  noc_output_unit #(.NUM_IN(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .pop_out(pop_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy_out(busy_out), .owner_out(owner_out), .err_out(err_out)
  );

  logic [DW-1:0] fifo [N][$];
  int checks = 0;
  int errors = 0;
  int grant_log[$];
  int pop_cnt[N];

  // reference model of the port
  int            m_owner = -1;
  int            m_left  = 0;
  int            m_rr    = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_err   = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] id, input int len);
    logic [DW-1:0] f;
    f = DW'($urandom);
    f[DW-1 -: 3] = id;
    if (id == HD) f[DW-4 -: LW] = LW'(len);
    return f;
  endfunction

  task automatic push_pkt(input int i, input int len, input int nfl);
    fifo[i].push_back(mk(HD, len));
    for (int k = 1; k < nfl; k++) fifo[i].push_back(mk((k == nfl - 1) ? TL : BD, 0));
  endtask

  function automatic int pick();
    logic [DW-1:0] h;
    if (rst) return -1;
    if (m_valid && !ready_in) return -1;
    if (m_owner >= 0) return (fifo[m_owner].size() > 0) ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (fifo[i].size() > 0) begin
        h = fifo[i][0];
        if (h[DW-1 -: 3] == HD) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_edge(input int p);
    logic [DW-1:0] f;
    int len;
    if (rst) begin
      m_owner = -1; m_left = 0; m_rr = 0; m_valid = 1'b0; m_data = '0; m_err = 1'b0;
      for (int i = 0; i < N; i++) fifo[i].delete();
      return;
    end
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (fifo[i].size() > 0) begin
          f = fifo[i][0];
          if (f[DW-1 -: 3] != HD) m_err = 1'b1;
        end
      end
    end
    if (p >= 0) begin
      f = fifo[p].pop_front();
      m_data = f;
      m_valid = 1'b1;
      len = int'(f[DW-4 -: LW]);
      if (m_owner < 0) begin
        if (len <= 1) m_rr = (p + 1) % N;
        else begin m_owner = p; m_left = len - 1; end
      end else begin
        if (f[DW-1 -: 3] == HD) m_err = 1'b1;
        if (f[DW-1 -: 3] == TL && m_left != 1) m_err = 1'b1;
        m_left = m_left - 1;
        if (f[DW-1 -: 3] == TL || m_left == 0) begin
          m_rr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (ready_in) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      int p;
      logic [DW-1:0] e;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_in[i] = (fifo[i].size() > 0);
        if (fifo[i].size() > 0) data_in[i*DW +: DW] = fifo[i][0];
        else data_in[i*DW +: DW] = '0;
      end
      #1;
      p = pick();
      e = (p >= 0) ? (DW'(1) << p) : '0;
      chk("pop_out", DW'(pop_out), e);
      for (int i = 0; i < N; i++) begin
        if (pop_out[i]) begin
          pop_cnt[i]++;
          if (!busy_out) grant_log.push_back(i);
        end
      end
      @(posedge clk);
      model_edge(p);
      #1;
      chk("data_out", data_out, m_data);
      chk("valid_out", DW'(valid_out), DW'(m_valid));
      chk("busy_out", DW'(busy_out), (m_owner >= 0) ? DW'(1) : DW'(0));
      chk("owner_out", DW'(owner_out), (m_owner >= 0) ? (DW'(1) << m_owner) : DW'(0));
      chk("err_out", DW'(err_out), DW'(m_err));
    end
  endtask

  task automatic clear_stats();
    grant_log.delete();
    for (int i = 0; i < N; i++) pop_cnt[i] = 0;
  endtask

  initial begin
    int exp_rr[6];
    int exp_edge[3];
    int len;
    int nfl;
    int tgt;
    int idx;
    logic [DW-1:0] tmp;
    exp_rr   = '{0, 1, 4, 0, 1, 4};
    exp_edge = '{0, 1, 0};

    // reset
    rst = 1'b1;
    run(2);
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", DW'(valid_out), 32'h0);
    chk("rst_owner", DW'(owner_out), 32'h0);
    rst = 1'b0;

    // single 4-flit packet on input 2
    clear_stats();
    push_pkt(2, 4, 4);
    run(4);
    chk("single_pops", DW'(pop_cnt[2]), 32'd4);
    run(3);
    chk("single_busy", DW'(busy_out), 32'd0);
    chk("single_err", DW'(err_out), 32'd0);

    // round-robin fairness from a fresh pointer
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    clear_stats();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 2, 2);
      push_pkt(1, 2, 2);
      push_pkt(4, 2, 2);
    end
    run(16);
    chk("rr_count", DW'(grant_log.size()), 32'd6);
    for (int g = 0; g < 6; g++) begin
      if (g < grant_log.size()) chk("rr_order", DW'(grant_log[g]), DW'(exp_rr[g]));
    end

    // backpressure mid-packet
    clear_stats();
    push_pkt(3, 6, 6);
    run(3);
    ready_in = 1'b0;
    run(3);
    ready_in = 1'b1;
    run(6);
    chk("bp_pops", DW'(pop_cnt[3]), 32'd6);

    // single-flit packets of length 1 and 0
    clear_stats();
    push_pkt(0, 1, 1);
    push_pkt(0, 0, 1);
    push_pkt(1, 1, 1);
    run(5);
    chk("edge_count", DW'(grant_log.size()), 32'd3);
    for (int g = 0; g < 3; g++) begin
      if (g < grant_log.size()) chk("edge_order", DW'(grant_log[g]), DW'(exp_edge[g]));
    end

    // errors: stray body at an idle head, early tail
    clear_stats();
    fifo[3].push_back(mk(BD, 0));
    push_pkt(1, 5, 2);
    push_pkt(2, 2, 2);
    run(8);
    chk("err_sticky", DW'(err_out), 32'd1);
    chk("err_nopop", DW'(pop_cnt[3]), 32'd0);
    chk("err_next", DW'(pop_cnt[2]), 32'd2);

    // reset at flit 3 of 6
    push_pkt(0, 6, 6);
    run(2);
    rst = 1'b1;
    run(1);
    chk("mrst_valid", DW'(valid_out), 32'd0);
    chk("mrst_owner", DW'(owner_out), 32'd0);
    chk("mrst_busy", DW'(busy_out), 32'd0);
    chk("mrst_err", DW'(err_out), 32'd0);
    rst = 1'b0;
    run(2);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        tgt = int'($urandom_range(N - 1));
        if (fifo[tgt].size() < 6) begin
          len = int'($urandom_range(6));
          nfl = (len <= 1) ? 1 : len;
          if (len >= 3 && $urandom_range(5) == 0) nfl = int'($urandom_range(len - 1, 2));
          push_pkt(tgt, len, nfl);
          if (nfl >= 3 && $urandom_range(7) == 0) begin
            idx = fifo[tgt].size() - 2;
            tmp = fifo[tgt][idx];
            tmp[DW-1 -: 3] = HD;
            fifo[tgt][idx] = tmp;
          end
        end
      end
      ready_in = ($urandom_range(3) != 0);
      run(1);
    end
    ready_in = 1'b1;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
